sram_responder: RTL and testbench

Synthesizable SRAM emulator that sits on the device side of the async-SRAM pin interface driven by `sram_controller`. It samples `ce_n`/`we_n`/`oe_n`/address/data and commits writes to an internal block RAM. On reads it drives the data bus from that RAM. Used for on-chip loopback of `sram_tester` without external SRAM, and as the bench-side memory in controller simulations.

---
 rtl/sram_responder_pkg.sv | 18 +
 rtl/sram_responder_mem.sv | 27 ++
 rtl/sram_responder.sv | 177 +++++++++++++++++
 tb/tb_sram_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_responder_pkg.sv
// sram_responder_pkg: shared types and constants for the SRAM pin-level emulator.
package sram_responder_pkg;

    // Debug-visible FSM encoding; values are exported on the state port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam int COUNT_BITS = 32;

    // Saturating increment used by the activity counters.
    function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sram_responder_mem.sv
// sram_responder_mem: synchronous block RAM backing store.
// Write has priority; a read of the address being written returns the old word.
// Read data is registered (1-cycle latency); contents are never reset.
module sram_responder_mem #(
    parameter int DATA_BITS     = 16,
    parameter int MEM_ADDR_BITS = 10
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [MEM_ADDR_BITS-1:0] i_waddr,
    input  logic [DATA_BITS-1:0]     i_wdata,
    input  logic                     i_re,
    input  logic [MEM_ADDR_BITS-1:0] i_raddr,
    output logic [DATA_BITS-1:0]     o_rdata
);

    logic [DATA_BITS-1:0] r_mem [0:(1<<MEM_ADDR_BITS)-1];

    // Plain clocked array access without reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        if (i_re)
            o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/sram_responder.sv
// sram_responder: device-side emulator of an async SRAM.
// Pins are sampled once, decoded by a small FSM, writes commit on WRITE exit,
// reads return data two cycles after the pins are first sampled.
// Optional feature macro: SRAM_RESPONDER_FAULT_EN (XOR read data with fault_mask).
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int ADDR_BITS     = 20,
    parameter int DATA_BITS     = 16,
    parameter int MEM_ADDR_BITS = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_BITS-1:0]  io_addr_bus,
    inout  wire  [DATA_BITS-1:0]  io_data_bus,
    input  logic                  io_we_n,
    input  logic                  io_oe_n,
    input  logic                  io_ce_n,
    output logic [1:0]            state,
    output logic                  data_oe,
    output logic [COUNT_BITS-1:0] write_count,
    output logic [COUNT_BITS-1:0] read_count,
    input  logic                  fault_en,
    input  logic [DATA_BITS-1:0]  fault_mask
);

    // sample stage
    logic [ADDR_BITS-1:0]     r_s_addr;
    logic [DATA_BITS-1:0]     r_s_data;
    logic                     r_s_we_n, r_s_oe_n, r_s_ce_n;

    state_t                   r_state, w_next;
    logic [MEM_ADDR_BITS-1:0] w_idx;
    logic                     w_commit, w_issue;

    logic [MEM_ADDR_BITS-1:0] r_pend_addr;
    logic [DATA_BITS-1:0]     r_pend_data;
    logic                     r_fwd_vld;
    logic [DATA_BITS-1:0]     r_fwd_data;
    logic                     r_rd_vld;
    logic [DATA_BITS-1:0]     r_fault_mask;
    logic [DATA_BITS-1:0]     w_mem_rdata, w_rdata;
    logic [DATA_BITS-1:0]     r_dout;
    logic                     r_data_oe;
    logic [COUNT_BITS-1:0]    r_write_count, r_read_count;
    logic                     w_unused_addr;

    assign w_idx         = r_s_addr[MEM_ADDR_BITS-1:0];
    // upper address bits alias and are deliberately not decoded
    assign w_unused_addr = ^r_s_addr;

    // Single register stage on every pin; reset parks the controls inactive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s_addr <= '0;
            r_s_data <= '0;
            r_s_we_n <= 1'b1;
            r_s_oe_n <= 1'b1;
            r_s_ce_n <= 1'b1;
        end else begin
            r_s_addr <= io_addr_bus;
            r_s_data <= io_data_bus;
            r_s_we_n <= io_we_n;
            r_s_oe_n <= io_oe_n;
            r_s_ce_n <= io_ce_n;
        end
    end

    // Next state depends only on sampled pins; write wins over output enable.
    always_comb begin
        w_next = IDLE;
        if (!r_s_ce_n) begin
            if (!r_s_we_n)
                w_next = WRITE;
            else if (!r_s_oe_n)
                w_next = READ;
        end
    end

    assign w_commit = (r_state == WRITE) && (w_next != WRITE);
    assign w_issue  = (w_next == READ);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Pending write tracks the latest sampled cycle with we_n low, so the
    // word committed on exit is the last one the controller presented.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_addr <= '0;
            r_pend_data <= '0;
        end else if (w_next == WRITE) begin
            r_pend_addr <= w_idx;
            r_pend_data <= r_s_data;
        end
    end

    // A WRITE->READ switch commits and fetches on the same edge; the RAM
    // returns the old word then, so the committed word is forwarded instead.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fwd_vld  <= 1'b0;
            r_fwd_data <= '0;
            r_rd_vld   <= 1'b0;
        end else begin
            r_fwd_vld  <= w_commit && w_issue && (r_pend_addr == w_idx);
            r_fwd_data <= r_pend_data;
            r_rd_vld   <= w_issue;
        end
    end

`ifdef SRAM_RESPONDER_FAULT_EN
    // Fault controls are captured alongside the read address so the mask lines up with its data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_fault_mask <= '0;
        else if (w_issue)
            r_fault_mask <= fault_en ? fault_mask : '0;
    end
`else
    logic w_unused_fault;
    assign w_unused_fault = fault_en ^ (^fault_mask);
    assign r_fault_mask   = '0;
`endif

    sram_responder_mem #(
        .DATA_BITS     (DATA_BITS),
        .MEM_ADDR_BITS (MEM_ADDR_BITS)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_commit),
        .i_waddr (r_pend_addr),
        .i_wdata (r_pend_data),
        .i_re    (w_issue),
        .i_raddr (w_idx),
        .o_rdata (w_mem_rdata)
    );

    assign w_rdata = r_fwd_vld ? r_fwd_data : w_mem_rdata;

    // Output register; the bus stays driven only while the read is still live.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout    <= '0;
            r_data_oe <= 1'b0;
        end else begin
            if (r_rd_vld)
                r_dout <= w_rdata ^ r_fault_mask;
            r_data_oe <= r_rd_vld && w_issue;
        end
    end

    // Saturating activity counters: one per commit, one per read fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write_count <= '0;
            r_read_count  <= '0;
        end else begin
            if (w_commit)
                r_write_count <= sat_inc(r_write_count);
            if (w_issue)
                r_read_count <= sat_inc(r_read_count);
        end
    end

    assign io_data_bus = r_data_oe ? r_dout : {DATA_BITS{1'bz}};
    assign data_oe     = r_data_oe;
    assign state       = r_state;
    assign write_count = r_write_count;
    assign read_count  = r_read_count;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: randomized checks against a word-array model of the SRAM.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [19:0] addr = '0;
    logic        we_n = 1'b1, oe_n = 1'b1, ce_n = 1'b1;
    logic [15:0] drv = '0;
    logic        drv_en = 1'b0;
    wire  [15:0] io_data_bus;
    logic [1:0]  state;
    logic        data_oe;
    logic [31:0] write_count, read_count;
    logic        fault_en = 1'b0;
    logic [15:0] fault_mask = '0;

    assign io_data_bus = drv_en ? drv : 16'bz;

    sram_responder #(.ADDR_BITS(20), .DATA_BITS(16), .MEM_ADDR_BITS(10)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .io_addr_bus (addr),
        .io_data_bus (io_data_bus),
        .io_we_n     (we_n),
        .io_oe_n     (oe_n),
        .io_ce_n     (ce_n),
        .state       (state),
        .data_oe     (data_oe),
        .write_count (write_count),
        .read_count  (read_count),
        .fault_en    (fault_en),
        .fault_mask  (fault_mask)
    );

    always #5 clk = ~clk;

    // model: memory image (1024 words, aliased by low address bits) and counters
    logic [15:0] mdl [1024];
    int          q_idx [$];
    int          exp_wc = 0, exp_rc = 0;
    int          n_checks = 0, n_fail = 0;

    function automatic logic [15:0] exp_read(input logic [19:0] a);
        logic [15:0] v;
        v = mdl[a[9:0]];
`ifdef SRAM_RESPONDER_FAULT_EN
        if (fault_en) v = v ^ fault_mask;
`endif
        return v;
    endfunction

    task automatic wr(input logic [19:0] a, input logic [15:0] d, input int len, input logic oe_too);
        @(negedge clk);
        ce_n = 1'b0; we_n = 1'b0; oe_n = ~oe_too; addr = a; drv = d; drv_en = 1'b1;
        repeat (len) @(negedge clk);
        ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; drv_en = 1'b0;
        repeat (3) @(negedge clk);
        mdl[a[9:0]] = d;
        q_idx.push_back(int'(a[9:0]));
        exp_wc++;
    endtask

    task automatic rd(input logic [19:0] a, input int hold, output logic [15:0] got,
                      output logic oe_early, output logic oe_on, output logic oe_hold, output logic oe_off);
        @(negedge clk);
        ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; addr = a;
        @(negedge clk);
        @(negedge clk);
        oe_early = data_oe;
        @(negedge clk);
        oe_on = data_oe;
        got   = io_data_bus;
        repeat (hold - 3) @(negedge clk);
        ce_n = 1'b1; oe_n = 1'b1;
        @(negedge clk);
        oe_hold = data_oe;
        @(negedge clk);
        oe_off = data_oe;
        @(negedge clk);
        exp_rc += hold;
    endtask

    // write for two cycles, then turn straight into a read with ce_n held low
    task automatic wr_rd(input logic [19:0] wa, input logic [15:0] d, input logic [19:0] ra, input int hold,
                         output logic [15:0] got, output logic oe_early, output logic oe_on);
        @(negedge clk);
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = wa; drv = d; drv_en = 1'b1;
        repeat (2) @(negedge clk);
        we_n = 1'b1; oe_n = 1'b0; addr = ra; drv_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        oe_early = data_oe;
        @(negedge clk);
        oe_on = data_oe;
        got   = io_data_bus;
        repeat (hold - 3) @(negedge clk);
        ce_n = 1'b1; oe_n = 1'b1;
        repeat (3) @(negedge clk);
        mdl[wa[9:0]] = d;
        q_idx.push_back(int'(wa[9:0]));
        exp_wc++;
        exp_rc += hold;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
        n_checks++; if (data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got=%b exp=0", data_oe); end
        n_checks++; if (write_count !== 32'd0) begin n_fail++; $display("FAIL reset_wc got=%0d exp=0", write_count); end
        n_checks++; if (read_count !== 32'd0) begin n_fail++; $display("FAIL reset_rc got=%0d exp=0", read_count); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read;
        logic [15:0] got; logic e, on, h, off;
        wr(20'h00003, 16'hA5A5, 2, 1'b0);
        n_checks++; if (write_count !== 32'(exp_wc)) begin n_fail++; $display("FAIL wr_count got=%0d exp=%0d", write_count, exp_wc); end
        rd(20'h00003, 3, got, e, on, h, off);
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL rd_oe_early got=%b exp=0", e); end
        n_checks++; if (on !== 1'b1) begin n_fail++; $display("FAIL rd_oe_on got=%b exp=1", on); end
        n_checks++; if (got !== 16'hA5A5) begin n_fail++; $display("FAIL rd_data got=%h exp=a5a5", got); end
        n_checks++; if (h !== 1'b1) begin n_fail++; $display("FAIL rd_oe_hold got=%b exp=1", h); end
        n_checks++; if (off !== 1'b0) begin n_fail++; $display("FAIL rd_oe_off got=%b exp=0", off); end
        n_checks++; if (read_count !== 32'(exp_rc)) begin n_fail++; $display("FAIL rd_count got=%0d exp=%0d", read_count, exp_rc); end
    endtask

    task automatic test_alias;
        logic [15:0] got; logic e, on, h, off;
        wr(20'h00400, 16'h1234, 1, 1'b0);
        rd(20'h00000, 4, got, e, on, h, off);
        n_checks++; if (got !== 16'h1234) begin n_fail++; $display("FAIL alias_data got=%h exp=1234", got); end
        n_checks++; if (on !== 1'b1) begin n_fail++; $display("FAIL alias_oe got=%b exp=1", on); end
    endtask

    task automatic test_we_oe_together;
        logic [15:0] got; logic e, on, h, off;
        logic [15:0] d;
        d = 16'($urandom);
        @(negedge clk);
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0; addr = 20'h00077; drv = d; drv_en = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL weoe_state got=%0d exp=1", state); end
        @(negedge clk);
        n_checks++; if (data_oe !== 1'b0) begin n_fail++; $display("FAIL weoe_oe got=%b exp=0", data_oe); end
        ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; drv_en = 1'b0;
        repeat (3) @(negedge clk);
        mdl[10'h077] = d; q_idx.push_back(32'h77); exp_wc++;
        n_checks++; if (write_count !== 32'(exp_wc)) begin n_fail++; $display("FAIL weoe_wc got=%0d exp=%0d", write_count, exp_wc); end
        rd(20'h00077, 3, got, e, on, h, off);
        n_checks++; if (got !== exp_read(20'h00077)) begin n_fail++; $display("FAIL weoe_data got=%h exp=%h", got, exp_read(20'h00077)); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] got, d, exp; logic e, on;
        logic [19:0] wa, ra;
        for (int i = 0; i < 6; i++) begin
            wa = 20'($urandom);
            d  = 16'($urandom);
            // even passes read the word just written, odd passes an older one
            ra = (i % 2 == 0) ? {10'($urandom), wa[9:0]} : {10'($urandom), 10'(q_idx[$urandom_range(0, q_idx.size()-1)])};
            wr_rd(wa, d, ra, 3 + (i % 2), got, e, on);
            exp = exp_read(ra);
            n_checks++; if (e !== 1'b0 || on !== 1'b1) begin n_fail++; $display("FAIL b2b_oe pass=%0d got=%b%b exp=01", i, e, on); end
            n_checks++; if (got !== exp) begin n_fail++; $display("FAIL b2b_data pass=%0d got=%h exp=%h", i, got, exp); end
        end
        n_checks++; if (write_count !== 32'(exp_wc) || read_count !== 32'(exp_rc)) begin
            n_fail++; $display("FAIL b2b_counts got=%0d/%0d exp=%0d/%0d", write_count, read_count, exp_wc, exp_rc); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] got, old; logic e, on, h, off;
        wr(20'h00155, 16'hBEEF, 2, 1'b0);
        old = mdl[10'h155];
        // reset in the middle of a write episode: nothing may be committed
        @(negedge clk);
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = 20'h00155; drv = 16'h0BAD; drv_en = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL rstw_state got=%0d exp=0", state); end
        n_checks++; if (write_count !== 32'd0) begin n_fail++; $display("FAIL rstw_wc got=%0d exp=0", write_count); end
        ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; drv_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_wc = 0; exp_rc = 0;
        repeat (2) @(negedge clk);
        n_checks++; if (write_count !== 32'd0) begin n_fail++; $display("FAIL rstw_nocommit got=%0d exp=0", write_count); end
        rd(20'h00155, 3, got, e, on, h, off);
        n_checks++; if (got !== old) begin n_fail++; $display("FAIL rstw_ram got=%h exp=%h", got, old); end
        // reset while the bus is driven: release without waiting for a clock
        @(negedge clk);
        ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; addr = 20'h00155;
        repeat (4) @(negedge clk);
        n_checks++; if (data_oe !== 1'b1) begin n_fail++; $display("FAIL rstr_pre got=%b exp=1", data_oe); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (data_oe !== 1'b0) begin n_fail++; $display("FAIL rstr_oe got=%b exp=0", data_oe); end
        n_checks++; if (read_count !== 32'd0) begin n_fail++; $display("FAIL rstr_rc got=%0d exp=0", read_count); end
        ce_n = 1'b1; oe_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        exp_wc = 0; exp_rc = 0;
        @(negedge clk);
    endtask

    task automatic test_fault;
        logic [15:0] got, exp; logic e, on, h, off;
        wr(20'h00042, 16'h00FF, 2, 1'b0);
        fault_en = 1'b1; fault_mask = 16'h0001;
`ifdef SRAM_RESPONDER_FAULT_EN
        exp = 16'h00FE;
`else
        exp = 16'h00FF;
`endif
        rd(20'h00042, 3, got, e, on, h, off);
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL fault_on got=%h exp=%h", got, exp); end
        fault_en = 1'b0;
        rd(20'h00042, 3, got, e, on, h, off);
        n_checks++; if (got !== 16'h00FF) begin n_fail++; $display("FAIL fault_off got=%h exp=00ff", got); end
        fault_mask = 16'h0000;
    endtask

    task automatic test_random;
        logic [15:0] got, exp; logic e, on, h, off;
        logic [19:0] a;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                a = 20'($urandom);
                wr(a, 16'($urandom), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
                n_checks++; if (write_count !== 32'(exp_wc)) begin n_fail++; $display("FAIL rnd_wc it=%0d got=%0d exp=%0d", i, write_count, exp_wc); end
            end else begin
                a = {10'($urandom), 10'(q_idx[$urandom_range(0, q_idx.size()-1)])};
                rd(a, $urandom_range(3, 6), got, e, on, h, off);
                exp = exp_read(a);
                n_checks++; if (got !== exp || on !== 1'b1 || off !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_rd it=%0d addr=%h got=%h oe=%b%b exp=%h oe=10", i, a, got, on, off, exp); end
                n_checks++; if (read_count !== 32'(exp_rc)) begin n_fail++; $display("FAIL rnd_rc it=%0d got=%0d exp=%0d", i, read_count, exp_rc); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alias();
        test_we_oe_together();
        test_back_to_back();
        test_reset_mid();
        test_fault();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
